// File: rtl/line_array_axil_regs_if.sv
// AXI4-Lite bus bundle for the line-array register file.
// The master modport is the BFM/bench side; the slave modport is the register file.
interface line_array_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
  logic [2:0]                        S_AXI_AWPROT;
  logic                              S_AXI_AWVALID;
  logic                              S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
  logic                              S_AXI_WVALID;
  logic                              S_AXI_WREADY;
  logic [1:0]                        S_AXI_BRESP;
  logic                              S_AXI_BVALID;
  logic                              S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
  logic [2:0]                        S_AXI_ARPROT;
  logic                              S_AXI_ARVALID;
  logic                              S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
  logic [1:0]                        S_AXI_RRESP;
  logic                              S_AXI_RVALID;
  logic                              S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/line_array_axil_regs.sv
// AXI4-Lite slave with four 32-bit control registers exported on REG_OUT.
// Define LINE_ARRAY_AXIL_SLVERR_EN to answer unmapped accesses with SLVERR.
module line_array_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  line_array_axil_regs_if.slave             s_axi,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   REG_OUT
);
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int SW       = DW / 8;
  localparam int NUM_REGS = 4;
  localparam int IDX_W    = AW - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {RD_IDLE, RD_VALID} rd_state_t;

  logic [NUM_REGS-1:0][DW-1:0] regs_reg;

  // Write channel state
  logic          aw_held_reg;
  logic          w_held_reg;
  logic          bvalid_reg;
  logic [1:0]    bresp_reg;
  logic [AW-1:0] awaddr_reg;
  logic [DW-1:0] wdata_reg;
  logic [SW-1:0] wstrb_reg;

  logic             aw_hs;
  logic             w_hs;
  logic             commit;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_strb;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_mapped;
  logic [1:0]       wr_resp;
  logic [NUM_REGS-1:0] wr_en;

  // Read channel state
  rd_state_t     rd_state_reg;
  rd_state_t     rd_state_next;
  logic          ar_ready_next;
  logic          rvalid_next;
  logic [DW-1:0] rdata_reg;
  logic [1:0]    rresp_reg;

  logic             ar_hs;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_mapped;
  logic [1:0]       rd_resp;

  assign s_axi.S_AXI_AWREADY = !aw_held_reg && !bvalid_reg && !ARESET;
  assign s_axi.S_AXI_WREADY  = !w_held_reg  && !bvalid_reg && !ARESET;
  assign s_axi.S_AXI_BVALID  = bvalid_reg;
  assign s_axi.S_AXI_BRESP   = bresp_reg;

  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID  && s_axi.S_AXI_WREADY;

  // A payload counts as available whether it was captured earlier or is handshaking now.
  assign commit  = (aw_held_reg || aw_hs) && (w_held_reg || w_hs);
  assign wr_addr = aw_held_reg ? awaddr_reg : s_axi.S_AXI_AWADDR;
  assign wr_data = w_held_reg  ? wdata_reg  : s_axi.S_AXI_WDATA;
  assign wr_strb = w_held_reg  ? wstrb_reg  : s_axi.S_AXI_WSTRB;
  assign wr_idx  = wr_addr[AW-1:2];
  assign wr_mapped = (wr_idx < IDX_W'(NUM_REGS));

`ifdef LINE_ARRAY_AXIL_SLVERR_EN
  assign wr_resp = wr_mapped ? RESP_OKAY : RESP_SLVERR;
`else
  assign wr_resp = RESP_OKAY;
`endif

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign wr_en[gi] = commit && wr_mapped && (wr_idx == IDX_W'(gi));
      assign REG_OUT[gi*DW +: DW] = regs_reg[gi];
    end
  endgenerate

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      regs_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        for (int b = 0; b < SW; b++) begin
          if (wr_en[r] && wr_strb[b]) begin
            regs_reg[r][b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
    end else begin
      if (aw_hs) begin
        awaddr_reg <= s_axi.S_AXI_AWADDR;
      end
      if (w_hs) begin
        wdata_reg <= s_axi.S_AXI_WDATA;
        wstrb_reg <= s_axi.S_AXI_WSTRB;
      end
      if (bvalid_reg && s_axi.S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
      // Readies are low while BVALID is up, so commit never overlaps a pending response.
      if (commit) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_resp;
      end else begin
        if (aw_hs) aw_held_reg <= 1'b1;
        if (w_hs)  w_held_reg  <= 1'b1;
      end
    end
  end

  assign rd_idx    = s_axi.S_AXI_ARADDR[AW-1:2];
  assign rd_mapped = (rd_idx < IDX_W'(NUM_REGS));

`ifdef LINE_ARRAY_AXIL_SLVERR_EN
  assign rd_resp = rd_mapped ? RESP_OKAY : RESP_SLVERR;
`else
  assign rd_resp = RESP_OKAY;
`endif

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_state_reg <= RD_IDLE;
    end else begin
      rd_state_reg <= rd_state_next;
    end
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    ar_ready_next = 1'b0;
    rvalid_next   = 1'b0;
    case (rd_state_reg)
      RD_IDLE: begin
        ar_ready_next = 1'b1;
        if (s_axi.S_AXI_ARVALID) rd_state_next = RD_VALID;
      end
      RD_VALID: begin
        rvalid_next = 1'b1;
        if (s_axi.S_AXI_RREADY) rd_state_next = RD_IDLE;
      end
      default: rd_state_next = RD_IDLE;
    endcase
  end

  assign s_axi.S_AXI_ARREADY = ar_ready_next && !ARESET;
  assign s_axi.S_AXI_RVALID  = rvalid_next;
  assign s_axi.S_AXI_RDATA   = rdata_reg;
  assign s_axi.S_AXI_RRESP   = rresp_reg;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;

  // Nonblocking sampling gives the pre-edge register value on a same-edge write.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rdata_reg <= '0;
      rresp_reg <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_reg <= rd_mapped ? regs_reg[rd_idx[1:0]] : '0;
      rresp_reg <= rd_resp;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         wr_addr[1:0], s_axi.S_AXI_ARADDR[1:0]};
endmodule

// File: tb/tb_line_array_axil_regs.sv
// Directed bench for line_array_axil_regs with a register-level reference model.
// Define LINE_ARRAY_AXIL_SLVERR_EN for both bench and RTL to exercise the SLVERR build.
module tb_line_array_axil_regs;
  logic         clk;
  logic         ARESET;
  logic [127:0] REG_OUT;

  int checks;
  int passes;

  logic [31:0] model_regs [4];

  line_array_axil_regs_if bus ();

  line_array_axil_regs dut (
    .ACLK    (clk),
    .ARESET  (ARESET),
    .s_axi   (bus.slave),
    .REG_OUT (REG_OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [127:0] model_concat();
    return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] addr);
    int idx;
    idx = int'(addr[4:2]);
    return (idx < 4) ? model_regs[idx] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [4:0] addr);
`ifdef LINE_ARRAY_AXIL_SLVERR_EN
    return (int'(addr[4:2]) < 4) ? 2'b00 : 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'(addr[4:2]);
    if (idx < 4) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) model_regs[idx][b*8 +: 8] = data[b*8 +: 8];
      end
    end
  endtask

  // Register contents must track the model on every clock outside reset.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!ARESET) chk("reg_out_vs_model", REG_OUT, model_concat());
    end
  end

  task automatic b_accept();
    bus.S_AXI_BREADY = 1'b1;
    @(posedge clk);
    #1;
    bus.S_AXI_BREADY = 1'b0;
    chk("bvalid_cleared", {127'b0, bus.S_AXI_BVALID}, 128'd0);
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input bit hold_b);
    bit aw_done, w_done, aw_go, w_go;
    int cyc;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    @(negedge clk);
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA  = data;
    bus.S_AXI_WSTRB  = strb;
    while (!(aw_done && w_done) && cyc < 30) begin
      bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
      bus.S_AXI_WVALID  = !w_done  && (cyc >= w_dly);
      #1;
      chk("bvalid_before_commit", {127'b0, bus.S_AXI_BVALID}, 128'd0);
      aw_go = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_go  = bus.S_AXI_WVALID  && bus.S_AXI_WREADY;
      @(posedge clk);
      #1;
      if (aw_go) begin aw_done = 1'b1; bus.S_AXI_AWVALID = 1'b0; end
      if (w_go)  begin w_done  = 1'b1; bus.S_AXI_WVALID  = 1'b0; end
      if (aw_done && w_done) model_write(addr, data, strb);
      @(negedge clk);
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      chk("write_timeout", 128'd0, 128'd1);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
    end else begin
      chk("bvalid_after_commit", {127'b0, bus.S_AXI_BVALID}, 128'd1);
      chk("bresp", {126'b0, bus.S_AXI_BRESP}, {126'b0, exp_resp(addr)});
      if (!hold_b) b_accept();
    end
  endtask

  task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp_data, input bit hold_r);
    int cyc;
    cyc = 0;
    @(negedge clk);
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    #1;
    while (!bus.S_AXI_ARREADY && cyc < 30) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!bus.S_AXI_ARREADY) begin
      chk("read_timeout", 128'd0, 128'd1);
      bus.S_AXI_ARVALID = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.S_AXI_ARVALID = 1'b0;
      @(negedge clk);
      chk("rvalid_after_ar", {127'b0, bus.S_AXI_RVALID}, 128'd1);
      chk("rdata", {96'b0, bus.S_AXI_RDATA}, {96'b0, exp_data});
      chk("rresp", {126'b0, bus.S_AXI_RRESP}, {126'b0, exp_resp(addr)});
      if (!hold_r) begin
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        #1;
        bus.S_AXI_RREADY = 1'b0;
        chk("rvalid_cleared", {127'b0, bus.S_AXI_RVALID}, 128'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wvals [4];
    logic [127:0] snap;
    checks = 0;
    passes = 0;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    wvals[0] = 32'h0101FFFF;
    wvals[1] = 32'hABCD0001;
    wvals[2] = 32'hDEAD0011;
    wvals[3] = 32'hBEEF0011;

    ARESET = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_reg_out", REG_OUT, 128'd0);
    chk("rst_bvalid", {127'b0, bus.S_AXI_BVALID}, 128'd0);
    chk("rst_rvalid", {127'b0, bus.S_AXI_RVALID}, 128'd0);
    chk("rst_awready_low", {127'b0, bus.S_AXI_AWREADY}, 128'd0);
    ARESET = 1'b0;
    #1;
    chk("post_rst_readies", {125'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 128'd7);

    // Round trip
    for (int i = 0; i < 4; i++) axi_write(5'(i*4), wvals[i], 4'hF, 0, 0, 1'b0);
    chk("roundtrip_reg_out", REG_OUT, 128'hBEEF0011_DEAD0011_ABCD0001_0101FFFF);
    for (int i = 0; i < 4; i++) axi_read(5'(i*4), wvals[i], 1'b0);
    axi_read(5'h0B, 32'hDEAD0011, 1'b0);

    // Byte strobes
    axi_write(5'h04, 32'h12345678, 4'b0101, 0, 0, 1'b0);
    axi_read(5'h04, 32'hAB340078, 1'b0);

    // Channel ordering: W leads AW by three cycles, then AW leads W by two
    axi_write(5'h0C, 32'h11223344, 4'hF, 3, 0, 1'b0);
    axi_read(5'h0C, 32'h11223344, 1'b0);
    axi_write(5'h00, 32'hCAFEF00D, 4'b1100, 0, 2, 1'b0);
    axi_read(5'h00, model_read(5'h00), 1'b0);
    chk("strobe_upper_half", {96'b0, model_regs[0]}, {96'b0, 32'hCAFEFFFF});

    // Second AW while the response is stalled
    axi_write(5'h0C, 32'h0F0F0F0F, 4'hF, 0, 0, 1'b1);
    bus.S_AXI_AWADDR  = 5'h04;
    bus.S_AXI_AWVALID = 1'b1;
    repeat (3) begin
      #1;
      chk("awready_while_bvalid", {127'b0, bus.S_AXI_AWREADY}, 128'd0);
      chk("bvalid_held", {127'b0, bus.S_AXI_BVALID}, 128'd1);
      @(negedge clk);
    end
    bus.S_AXI_AWVALID = 1'b0;
    b_accept();

    // Same-edge write commit and read of REG2
    @(negedge clk);
    bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_WDATA = 32'h55AA55AA; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_ARADDR = 5'h08;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
    #1;
    chk("collision_readies", {125'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 128'd7);
    @(posedge clk);
    #1;
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    model_write(5'h08, 32'h55AA55AA, 4'hF);
    @(negedge clk);
    chk("collision_bvalid", {127'b0, bus.S_AXI_BVALID}, 128'd1);
    chk("collision_rvalid", {127'b0, bus.S_AXI_RVALID}, 128'd1);
    chk("collision_old_data", {96'b0, bus.S_AXI_RDATA}, {96'b0, 32'hDEAD0011});
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    @(posedge clk);
    #1;
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    axi_read(5'h08, 32'h55AA55AA, 1'b0);

    // Unmapped slot
    snap = REG_OUT;
    axi_write(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0);
    chk("unmapped_no_change", REG_OUT, snap);
    axi_read(5'h14, 32'h0, 1'b0);
    axi_read(5'h1C, 32'h0, 1'b0);

    // Reset with both responses pending
    axi_write(5'h04, 32'h77777777, 4'hF, 0, 0, 1'b1);
    axi_read(5'h00, model_read(5'h00), 1'b1);
    #2;
    ARESET = 1'b1;
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    #1;
    chk("rst_mid_bvalid", {127'b0, bus.S_AXI_BVALID}, 128'd0);
    chk("rst_mid_rvalid", {127'b0, bus.S_AXI_RVALID}, 128'd0);
    chk("rst_mid_reg_out", REG_OUT, 128'd0);
    chk("rst_mid_rdata", {96'b0, bus.S_AXI_RDATA}, 128'd0);
    @(negedge clk);
    ARESET = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_readies", {125'b0, bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 128'd7);
    chk("rst_release_no_resp", {126'b0, bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 128'd0);
    axi_write(5'h08, 32'hA5A5A5A5, 4'hF, 0, 0, 1'b0);
    axi_read(5'h08, 32'hA5A5A5A5, 1'b0);
    axi_read(5'h04, 32'h0, 1'b0);

    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
